// File: rtl/hrm_pkg.sv
// hrm_pkg: shared constants and types for the PPG sample path.
// Half-set of the symmetric low-pass FIR taps plus the MAC FSM states.
package hrm_pkg;

    localparam int FIR_NTAPS  = 31;
    localparam int FIR_SHIFT  = 10;
    localparam int FIR_COEF_W = 8;

    // Taps 0..15 of the 31-tap filter; tap 30-k equals tap k.
    localparam logic [FIR_COEF_W-1:0] FIR_COEF [0:15] = '{
        8'd3,  8'd4,  8'd6,  8'd8,
        8'd12, 8'd17, 8'd23, 8'd29,
        8'd36, 8'd43, 8'd50, 8'd56,
        8'd61, 8'd65, 8'd67, 8'd68
    };

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SCALE
    } fir_state_t;

endpackage

// File: rtl/fir_tap_buffer.sv
// fir_tap_buffer: circular delay line for the FIR sequencer.
// One write port, two combinational read ports, async active-low clear.
module fir_tap_buffer #(
    parameter int DATA_W = 10,
    parameter int NTAPS  = 31,
    parameter int AW     = $clog2(NTAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NTAPS];

    // Sample history; cleared on reset so a restart sees zero history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: 31-tap symmetric FIR run on one shared multiplier.
// Each accepted sample takes 16 MAC steps plus one scaling step.
module fir_mac_sequencer
    import hrm_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int NTAPS  = FIR_NTAPS,
    parameter int COEF_W = FIR_COEF_W,
    parameter int ACC_W  = 22,
    parameter int SHIFT  = FIR_SHIFT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              clr_overrun,
    output logic              busy,
    output logic              result_valid,
    output logic [DATA_W-1:0] result,
    output logic              overrun
);

    localparam int AW    = $clog2(NTAPS);
    localparam int NHALF = (NTAPS + 1) / 2;
    localparam int KW    = $clog2(NHALF);
    localparam int PW    = DATA_W + 1 + COEF_W;

    localparam logic [AW:0]   N_EXT  = (AW+1)'(NTAPS);
    localparam logic [AW-1:0] WP_MAX = AW'(NTAPS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NHALF - 1);

    fir_state_t state;
    fir_state_t state_nxt;

    logic accept;
    logic mac_step;
    logic do_scale;
    logic last_step;

    logic [AW-1:0]     wp;
    logic [AW-1:0]     wp_last;
    logic [AW:0]       k_ext;
    logic [AW:0]       sum_a;
    logic [AW:0]       sum_b;
    logic [AW-1:0]     addr_a;
    logic [AW-1:0]     addr_b;
    logic [KW-1:0]     k;
    logic [DATA_W-1:0] tap_a;
    logic [DATA_W-1:0] tap_b;
    logic [DATA_W:0]   pair;
    logic [COEF_W-1:0] coef;
    logic [PW-1:0]     prod;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0] sat;

    fir_tap_buffer #(
        .DATA_W (DATA_W),
        .NTAPS  (NTAPS),
        .AW     (AW)
    ) u_taps (
        .clk     (clk),
        .reset   (reset),
        .we      (accept),
        .waddr   (wp),
        .wdata   (sample_in),
        .raddr_a (addr_a),
        .raddr_b (addr_b),
        .rdata_a (tap_a),
        .rdata_b (tap_b)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        mac_step  = 1'b0;
        do_scale  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sample_valid) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_step = 1'b1;
                if (k == K_LAST) begin
                    state_nxt = SCALE;
                end
            end
            SCALE: begin
                do_scale  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Age k sits at wp_last-k; age 30-k folds to wp+k since wp = wp_last+1.
    always_comb begin
        wp_last = (wp == '0) ? WP_MAX : wp - 1'b1;
        k_ext   = (AW+1)'(k);
        sum_a   = {1'b0, wp_last} + N_EXT - k_ext;
        sum_b   = {1'b0, wp} + k_ext;
        addr_a  = (sum_a >= N_EXT) ? AW'(sum_a - N_EXT) : AW'(sum_a);
        addr_b  = (sum_b >= N_EXT) ? AW'(sum_b - N_EXT) : AW'(sum_b);
    end

    // Folded pair times coefficient; the centre tap is used alone.
    always_comb begin
        last_step = (k == K_LAST);
        coef      = COEF_W'(FIR_COEF[k]);
        if (last_step) begin
            pair = {1'b0, tap_a};
        end else begin
            pair = {1'b0, tap_a} + {1'b0, tap_b};
        end
        prod = {{COEF_W{1'b0}}, pair} * {{(DATA_W+1){1'b0}}, coef};
    end

    // Scale the accumulator and clip to full scale.
    always_comb begin
        shifted = acc >> SHIFT;
        if (shifted > ACC_W'({DATA_W{1'b1}})) begin
            sat = '1;
        end else begin
            sat = shifted[DATA_W-1:0];
        end
    end

    // Write pointer, step counter, accumulator and output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp           <= '0;
            k            <= '0;
            acc          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= do_scale;
            if (accept) begin
                wp  <= (wp == WP_MAX) ? '0 : wp + 1'b1;
                k   <= '0;
                acc <= '0;
            end
            if (mac_step) begin
                k   <= k + 1'b1;
                acc <= acc + ACC_W'(prod);
            end
            if (do_scale) begin
                result <= sat;
            end
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (sample_valid && busy) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    // Result strobe is a single-cycle pulse issued only while idle.
    a_rv_pulse: assert property (@(posedge clk) disable iff (!reset)
        result_valid |=> !result_valid);
    a_rv_idle: assert property (@(posedge clk) disable iff (!reset)
        result_valid |-> !busy);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed tests for the time-multiplexed FIR.
// Expected values are hand-derived or from a direct 31-tap convolution.
module tb_fir_mac_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [9:0] sample_in = '0;
    logic       clr_overrun = 1'b0;
    logic       busy;
    logic       result_valid;
    logic [9:0] result;
    logic       overrun;

    int pass_cnt = 0;
    int total = 0;

    int hist [31];
    int coef_half [16] = '{3, 4, 6, 8, 12, 17, 23, 29,
                           36, 43, 50, 56, 61, 65, 67, 68};
    int imp [31] = '{2, 3, 5, 7, 11, 16, 22, 28, 35, 41, 48,
                     54, 59, 63, 65, 66, 65, 63, 59, 54, 48,
                     41, 35, 28, 22, 16, 11, 7, 5, 3, 2};

    fir_mac_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .clr_overrun  (clr_overrun),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    function automatic int model_push(input int v);
        int acc;
        for (int i = 30; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        acc = 0;
        for (int i = 0; i < 31; i++)
            acc += coef_half[(i <= 15) ? i : 30 - i] * hist[i];
        acc = acc >> 10;
        if (acc > 1023) acc = 1023;
        return acc;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 31; i++) hist[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        sample_valid = 1'b0;
        clr_overrun = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where result_valid is seen.
    task automatic run_sample(input int v, output logic [9:0] r,
                              output int lat, output int exp);
        sample_valid = 1'b1;
        sample_in = v[9:0];
        @(negedge clk);
        sample_valid = 1'b0;
        exp = model_push(v);
        lat = 0;
        while (result_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        r = result;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else pass_cnt++;
        total++;
        if (result_valid !== 1'b0) $display("FAIL reset_rv got %b want 0", result_valid);
        else pass_cnt++;
        total++;
        if (result !== 10'd0) $display("FAIL reset_result got %0d want 0", result);
        else pass_cnt++;
        total++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [9:0] r;
        int lat, exp;
        run_sample(1000, r, lat, exp);
        total++;
        if (lat !== 17) $display("FAIL single_latency got %0d want 17", lat);
        else pass_cnt++;
        total++;
        if (r !== 10'd2) $display("FAIL single_result got %0d want 2", r);
        else pass_cnt++;
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0) $display("FAIL single_rv_pulse got %b want 0", result_valid);
        else pass_cnt++;
        total++;
        if (result !== 10'd2) $display("FAIL single_hold got %0d want 2", result);
        else pass_cnt++;
    endtask

    task automatic test_impulse();
        logic [9:0] r;
        int lat, exp;
        do_reset();
        for (int i = 0; i < 31; i++) begin
            run_sample((i == 0) ? 1000 : 0, r, lat, exp);
            total++;
            if (r !== 10'(imp[i]))
                $display("FAIL impulse[%0d] got %0d want %0d", i, r, imp[i]);
            else pass_cnt++;
        end
        total++;
        if (lat !== 17) $display("FAIL impulse_latency got %0d want 17", lat);
        else pass_cnt++;
    endtask

    task automatic test_const512();
        logic [9:0] r;
        int lat, exp;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            run_sample(512, r, lat, exp);
            if (i >= 30) begin
                total++;
                if (r !== 10'd514)
                    $display("FAIL dc512[%0d] got %0d want 514", i, r);
                else pass_cnt++;
            end else if (i % 5 == 0) begin
                total++;
                if (r !== 10'(exp))
                    $display("FAIL ramp512[%0d] got %0d want %0d", i, r, exp);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_saturate();
        logic [9:0] r;
        int lat, exp;
        for (int i = 0; i < 40; i++) begin
            run_sample(1023, r, lat, exp);
            if (i >= 30) begin
                total++;
                if (r !== 10'd1023)
                    $display("FAIL sat1023[%0d] got %0d want 1023", i, r);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_overrun();
        int lat, exp;
        do_reset();
        sample_valid = 1'b1;
        sample_in = 10'd1000;
        @(negedge clk);
        sample_valid = 1'b0;
        exp = model_push(1000);
        repeat (4) @(negedge clk);
        sample_valid = 1'b1;
        sample_in = 10'd500;
        @(negedge clk);
        sample_valid = 1'b0;
        total++;
        if (overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", overrun);
        else pass_cnt++;
        lat = 5;
        while (result_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== 17) $display("FAIL ovr_latency got %0d want 17", lat);
        else pass_cnt++;
        total++;
        if (result !== 10'd2) $display("FAIL ovr_result got %0d want 2", result);
        else pass_cnt++;
        total++;
        if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun);
        else pass_cnt++;
        sample_valid = 1'b1;
        sample_in = 10'd0;
        @(negedge clk);
        sample_valid = 1'b0;
        exp = model_push(0);
        @(negedge clk);
        sample_valid = 1'b1;
        clr_overrun = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b1) $display("FAIL ovr_set_wins got %b want 1", overrun);
        else pass_cnt++;
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        total++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", overrun);
        else pass_cnt++;
        lat = 0;
        while (result_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (result !== 10'd3) $display("FAIL ovr_next_result got %0d want 3", result);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [9:0] r;
        int lat, exp;
        int seen;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in = 10'd700;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        total++;
        if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy);
        else pass_cnt++;
        total++;
        if (result !== 10'd0) $display("FAIL mid_result got %0d want 0", result);
        else pass_cnt++;
        total++;
        if (overrun !== 1'b0) $display("FAIL mid_overrun got %b want 0", overrun);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL mid_no_rv got %0d strobes want 0", seen);
        else pass_cnt++;
        run_sample(1000, r, lat, exp);
        total++;
        if (r !== 10'd2) $display("FAIL mid_restart got %0d want 2", r);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [9:0] r;
        int lat, exp, v;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            v = int'($urandom_range(0, 1023));
            run_sample(v, r, lat, exp);
            total++;
            if (r !== 10'(exp) || lat !== 17)
                $display("FAIL rand[%0d] got %0d lat %0d want %0d lat 17",
                         i, r, lat, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_impulse();
        test_const512();
        test_saturate();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
